// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage that owns the PC, issues reads to a synchronous
// instruction memory (1-cycle latency), and buffers returned words in a small
// FIFO. Downstream stalls therefore never drop an instruction. A redirect
// flushes both the in-flight read and all buffered words.
// Optional feature macro: IFETCH_MISALIGN_TRAP_EN. When it is defined, a
// misaligned redirect raises a sticky fetch_fault and halts issue.
module instr_fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter int                IMEM_AW    = 10,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               fetch_fault
);

  localparam int                PTR_W      = $clog2(FIFO_DEPTH);
  localparam int                CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0]  LAST_IDX   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]    DEPTH_C    = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);

  logic [ADDR_W-1:0] fetch_pc;
  logic              inflight_valid;
  logic [ADDR_W-1:0] inflight_pc;

  logic [31:0]       fifo_instr [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       last_instr;
  logic [ADDR_W-1:0] last_pc;

  logic              pop;
  logic              issue;
  logic              halted;
  logic [CNT_W:0]    credit_sum;

  // Ring-buffer pointer advance. It also works for depths that are not a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready;

  // Credit rule: buffered words plus the word in flight, minus the word leaving
  // this cycle, must leave room. This makes an overflow impossible.
  assign credit_sum = {1'b0, count}
                    + {{CNT_W{1'b0}}, inflight_valid}
                    - {{CNT_W{1'b0}}, pop};

  // Issue decision. A redirect, reset or trap halt suppresses the read strobe.
  always_comb begin
    issue     = 1'b0;
    imem_addr = '0;
    if (!rst) begin
      imem_addr = fetch_pc[IMEM_AW+1:2];
      issue     = !redirect_valid && !halted && (credit_sum < DEPTH_C);
    end
    imem_en = issue;
  end

  // PC and in-flight tag. The issued PC travels with its read so the
  // returning word can be tagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc       <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
    end else if (redirect_valid) begin
      fetch_pc       <= redirect_pc & ALIGN_MASK;
      inflight_valid <= 1'b0;
    end else begin
      inflight_valid <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + PC_STEP;
        inflight_pc <= fetch_pc;
      end
    end
  end

  // FIFO storage. Only returning words that survive a flush are captured.
  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid && inflight_valid) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= inflight_pc;
    end
  end

  // FIFO control. This block also keeps the last popped word so the outputs
  // hold steady when the buffer is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      last_instr <= '0;
      last_pc    <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (inflight_valid) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr     <= ptr_inc(rd_ptr);
        last_instr <= fifo_instr[rd_ptr];
        last_pc    <= fifo_pc[rd_ptr];
      end
      count <= count + CNT_W'(inflight_valid) - CNT_W'(pop);
    end
  end

  assign instr    = instr_valid ? fifo_instr[rd_ptr] : last_instr;
  assign instr_pc = instr_valid ? fifo_pc[rd_ptr]    : last_pc;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic fault_q;

  // Sticky misalignment trap. Only reset clears it, and it stops all further issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      fault_q <= 1'b1;
    end
  end

  assign fetch_fault = fault_q;
  assign halted      = fault_q;
`else
  assign fetch_fault = 1'b0;
  assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench for instr_fetch_unit with default
// parameters. A small synchronous memory model returns a distinct word per
// address. When IFETCH_MISALIGN_TRAP_EN is defined, the misaligned-redirect
// expectations switch to the trap behaviour.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  int compared;
  int mismatched;

  instr_fetch_unit #(
    .ADDR_W(32), .IMEM_AW(10), .RESET_PC(32'h0), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content: a distinct word for each word address.
  function automatic logic [31:0] wordOf(input logic [9:0] a);
    return 32'hA5C3_0000 + {22'b0, a};
  endfunction

  // Synchronous instruction memory with a one-cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= wordOf(imem_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expectHead(input string tag, input logic [31:0] pc);
    logic [31:0] p;
    p = pc;
    checkOutput({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    checkOutput({tag, "_pc"}, instr_pc, pc);
    checkOutput({tag, "_word"}, instr, wordOf(p[11:2]));
  endtask

  // The reset edge itself starts cycle 0 once rst is released.
  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Redirect in the current cycle, then check the restart latency and the first two heads.
  task automatic redirectSeq(input string tag, input logic [31:0] target);
    logic [31:0] aligned;
    logic [9:0]  a0;
    aligned = target & 32'hFFFF_FFFC;
    a0      = aligned[11:2];
    applyStimulus(1'b1, target, 1'b1);
    @(negedge clk);
    checkOutput({tag, "_en_r"}, {31'b0, imem_en}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    checkOutput({tag, "_empty_r1"}, {31'b0, instr_valid}, 32'd0);
    checkOutput({tag, "_en_r1"}, {31'b0, imem_en}, 32'd1);
    checkOutput({tag, "_addr_r1"}, {22'b0, imem_addr}, {22'b0, a0});
    nextCycle();
    @(negedge clk);
    checkOutput({tag, "_empty_r2"}, {31'b0, instr_valid}, 32'd0);
    checkOutput({tag, "_addr_r2"}, {22'b0, imem_addr}, {22'b0, a0 + 10'd1});
    nextCycle();
    @(negedge clk);
    expectHead({tag, "_head0"}, aligned);
    checkOutput({tag, "_addr_r3"}, {22'b0, imem_addr}, {22'b0, a0 + 10'd2});
    nextCycle();
    @(negedge clk);
    expectHead({tag, "_head1"}, aligned + 32'd4);
    nextCycle();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);

    // Reset values.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_pc", instr_pc, 32'd0);
    checkOutput("rst_en", {31'b0, imem_en}, 32'd0);
    checkOutput("rst_addr", {22'b0, imem_addr}, 32'd0);
    checkOutput("rst_fault", {31'b0, fetch_fault}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Free-running stream with ready held high.
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("stream_en", {31'b0, imem_en}, 32'd1);
      checkOutput("stream_addr", {22'b0, imem_addr}, c);
      if (c < 2) checkOutput("stream_novalid", {31'b0, instr_valid}, 32'd0);
      else       expectHead("stream", 4 * (c - 2));
      nextCycle();
    end

    // Back-pressure: ten stalled cycles buffer exactly four words.
    applyStimulus(1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      expectHead("stall", 32'd32);
      checkOutput("stall_en", {31'b0, imem_en}, (k < 2) ? 32'd1 : 32'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      expectHead("drain", 32'd32 + 4 * k);
      nextCycle();
    end

    // Redirect to 0x40 in cycle 5 of a fresh stream.
    resetDut();
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int c = 0; c < 5; c++) nextCycle();
    @(negedge clk);
    expectHead("pre_redir", 32'd12);
    redirectSeq("redir40", 32'h40);

    // Redirect while the FIFO is full and the consumer pops in the same cycle.
    resetDut();
    applyStimulus(1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 8; c++) nextCycle();
    @(negedge clk);
    expectHead("full_head", 32'd0);
    checkOutput("full_en", {31'b0, imem_en}, 32'd0);
    redirectSeq("full_redir", 32'h40);

    // PC wrap across the top of the address space.
    redirectSeq("wrap", 32'hFFFF_FFF8);
    @(negedge clk);
    expectHead("wrap_zero", 32'h0);
    nextCycle();

    // Misaligned redirect target.
`ifdef IFETCH_MISALIGN_TRAP_EN
    applyStimulus(1'b1, 32'h42, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("trap_fault", {31'b0, fetch_fault}, 32'd1);
      checkOutput("trap_novalid", {31'b0, instr_valid}, 32'd0);
      checkOutput("trap_en", {31'b0, imem_en}, 32'd0);
      nextCycle();
    end
    resetDut();
    @(negedge clk);
    checkOutput("trap_cleared", {31'b0, fetch_fault}, 32'd0);
    nextCycle();
`else
    redirectSeq("misalign", 32'h42);
    @(negedge clk);
    checkOutput("misalign_fault", {31'b0, fetch_fault}, 32'd0);
    nextCycle();
`endif

    // A mid-stream reset discards everything, and the stream restarts from RESET_PC.
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midrst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("midrst_en", {31'b0, imem_en}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c < 2) checkOutput("midrst_novalid", {31'b0, instr_valid}, 32'd0);
      else       expectHead("midrst_stream", 4 * (c - 2));
      nextCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
